// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a missing cache line as LINE_WORDS sequential word reads and writes it into the cache
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_addr/rd/wr, miss: CPU request and cache miss indication; a miss with a request starts a refill
//   stall               : pipeline hold, high from miss detection through the DONE cycle
//   mem_rd_*            : one-outstanding word read port (strobe/address out, data/valid in)
//   update_*            : assembled line, line-aligned address and one-cycle write strobe to the cache
//   err, err_clr        : sticky memory-timeout flag and its clear
module cache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cpu_addr,
    input  logic                    cpu_rd_en,
    input  logic                    cpu_wr_en,
    input  logic                    miss,
    output logic                    stall,
    output logic                    mem_rd_en,
    output logic [31:0]             mem_rd_addr,
    input  logic [31:0]             mem_rd_data,
    input  logic                    mem_rd_valid,
    output logic [32*LINE_WORDS-1:0] update_data,
    output logic                    update_en,
    output logic [31:0]             refill_addr,
    output logic                    err,
    input  logic                    err_clr
);
    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, UPDATE, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] wcnt;
    logic          start, last, tmo;

    always_comb begin
        start       = miss && (cpu_rd_en || cpu_wr_en);
        last        = cnt == CW'(LINE_WORDS - 1);
        tmo         = !mem_rd_valid && wcnt == TW'(TIMEOUT - 1);
        // the detection term is gated by rst so every output reads 0 while reset is held
        stall       = !rst && (state != IDLE || start);
        mem_rd_en   = state == REQ;
        mem_rd_addr = mem_rd_en ? refill_addr + 32'({cnt, 2'b00}) : '0;
        update_en   = state == UPDATE;
        state_nxt   = state;
        case (state)
            IDLE:    state_nxt = start ? REQ : IDLE;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = mem_rd_valid ? (last ? UPDATE : REQ) : (tmo ? IDLE : WAIT);
            UPDATE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wcnt        <= '0;
            refill_addr <= '0;
            update_data <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            // a timeout in the same cycle as err_clr keeps the flag set
            err   <= (state == WAIT && tmo) || (err && !err_clr);
            if (state == IDLE && start) begin
                refill_addr <= cpu_addr & ~LINE_MASK;
                cnt         <= '0;
                wcnt        <= '0;
            end
            if (state == REQ)
                wcnt <= '0;
            if (state == WAIT) begin
                if (mem_rd_valid) begin
                    update_data[{cnt, 5'b0} +: 32] <= mem_rd_data;
                    if (!last)
                        cnt <= cnt + 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: scoreboard bench for cache_refill_ctrl with a latency-configurable memory model
module tb_cache_refill_ctrl;
    logic         clk = 0, rst = 1;
    logic [31:0]  cpu_addr = 0;
    logic         cpu_rd_en = 0, cpu_wr_en = 0, miss = 0, err_clr = 0;
    logic         stall, mem_rd_en, mem_rd_valid, update_en, err;
    logic [31:0]  mem_rd_addr, mem_rd_data, refill_addr;
    logic [255:0] update_data;
    logic         mv = 0, sv = 0;
    logic [31:0]  md = 0, sd = 0;
    int           vec = 0, bad = 0, cyc = 0;
    int           lat_e = 1, lat_o = 1, hold = -1;
    logic [31:0]  dbase = 0;

    typedef struct {int c; logic [31:0] a; logic [255:0] d;} upd_t;
    logic [31:0] rd_q[$];
    upd_t        upd_q[$];
    upd_t        um;

    assign mem_rd_valid = mv | sv;
    assign mem_rd_data  = sv ? sd : md;

    cache_refill_ctrl #(.LINE_WORDS(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .miss(miss), .stall(stall), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .update_data(update_data),
        .update_en(update_en), .refill_addr(refill_addr), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = b + 32'(k);
        return r;
    endfunction

    // monitor: every read strobe and every line write is matched against the scoreboard
    always @(negedge clk) begin
        if (mem_rd_en) begin
            if (rd_q.size() == 0) chk("mem_rd_en unexpected", mem_rd_en, 0);
            else chk("mem_rd_addr", mem_rd_addr, rd_q.pop_front());
        end
        if (update_en) begin
            if (upd_q.size() == 0) chk("update_en unexpected", update_en, 0);
            else begin
                um = upd_q.pop_front();
                chk("update_en cycle", cyc, um.c);
                chk("refill_addr", refill_addr, um.a);
                chk("update_data", update_data, um.d);
            end
        end
    end

    // memory model: word k returns dbase+k, latency lat_e/lat_o by word parity, word 'hold' never returns
    initial begin
        int mk, ml;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                mk = int'(mem_rd_addr[4:2]);
                ml = mk[0] ? lat_o : lat_e;
                repeat (ml) @(posedge clk);
                #1;
                if (mk != hold) begin
                    mv = 1;
                    md = dbase + 32'(mk);
                    tick();
                    mv = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
        $fatal(1);
    end

    // drives a miss from the current cycle t0; stall is checked every cycle through DONE
    task automatic run_refill(input logic [31:0] a, input logic wr, input bit chain, input bit spur);
        int   n;
        upd_t u;
        n = 1;
        for (int k = 0; k < 8; k++) begin
            rd_q.push_back((a & ~32'h1F) + 32'(4 * k));
            n += (((k % 2) != 0) ? lat_o : lat_e) + 1;
        end
        u.c = cyc + n;
        u.a = a & ~32'h1F;
        u.d = line_of(dbase);
        upd_q.push_back(u);
        cpu_addr  = a;
        cpu_rd_en = !wr;
        cpu_wr_en = wr;
        for (int i = 0; i <= n + 1; i++) begin
            miss = 1;
            sv   = spur && i < 2;
            sd   = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stall during refill", stall, 1);
            tick();
        end
        sv = 0;
        if (!chain) begin
            miss      = 0;
            cpu_rd_en = 0;
            cpu_wr_en = 0;
            @(negedge clk);
            chk("stall after DONE", stall, 0);
            tick();
        end
    endtask

    // word 2 is withheld; with L=1 the abort happens in t0+9 and err/stall settle in t0+10
    task automatic run_timeout(input logic [31:0] a, input bit clr_at_abort);
        hold = 2;
        for (int k = 0; k < 3; k++) rd_q.push_back(a + 32'(4 * k));
        cpu_addr  = a;
        cpu_rd_en = 1;
        miss      = 1;
        for (int i = 0; i <= 9; i++) begin
            err_clr = clr_at_abort && i == 9;
            @(negedge clk);
            chk("stall while waiting", stall, 1);
            tick();
        end
        err_clr   = 0;
        miss      = 0;
        cpu_rd_en = 0;
        @(negedge clk);
        chk("err after timeout", err, 1);
        chk("stall after timeout", stall, 0);
        tick();
        hold = -1;
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, " stall"}, stall, 0);
        chk({n, " mem_rd_en"}, mem_rd_en, 0);
        chk({n, " mem_rd_addr"}, mem_rd_addr, 0);
        chk({n, " update_en"}, update_en, 0);
        chk({n, " update_data"}, update_data, 0);
        chk({n, " refill_addr"}, refill_addr, 0);
        chk({n, " err"}, err, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 0;
        tick();

        dbase = 32'hA0;
        run_refill(32'h0000_1234, 0, 0, 0);

        lat_e = 3;
        dbase = 32'h1000;
        run_refill(32'h0000_5678, 0, 0, 0);
        lat_e = 1;

        for (int i = 0; i < 6; i++) begin
            cpu_addr  = 32'h100 * 32'(i);
            cpu_rd_en = i < 4 && i[0];
            cpu_wr_en = i < 4 && !i[0];
            miss      = i >= 4;
            sv        = i < 3;
            sd        = 32'hBAD0_0000 + 32'(i);
            @(negedge clk);
            chk("stall on hit", stall, 0);
            chk("mem_rd_en on hit", mem_rd_en, 0);
            tick();
        end
        sv = 0; miss = 0; cpu_rd_en = 0; cpu_wr_en = 0;

        dbase = 32'h3300;
        run_refill(32'h0000_9ABC, 0, 0, 1);

        @(negedge clk);
        chk("err before timeout", err, 0);
        tick();
        run_timeout(32'h0000_7000, 0);
        dbase = 32'h4400;
        run_refill(32'h0000_7004, 0, 0, 0);
        @(negedge clk);
        chk("err held across refill", err, 1);
        tick();
        run_timeout(32'h0000_7100, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        @(negedge clk);
        chk("err after clear", err, 0);
        tick();

        dbase     = 32'h5500;
        cpu_addr  = 32'h0000_2000;
        cpu_rd_en = 1;
        miss      = 1;
        for (int k = 0; k < 6; k++) rd_q.push_back(32'h2000 + 32'(4 * k));
        repeat (12) tick();
        #2 rst = 1;
        #1;
        chk_all_zero("async reset");
        tick();
        miss = 0; cpu_rd_en = 0; rst = 0;
        repeat (3) tick();
        dbase = 32'h6600;
        run_refill(32'h0000_2000, 0, 0, 0);

        dbase = 32'h7700;
        run_refill(32'h0000_0040, 1, 1, 0);
        dbase = 32'h8800;
        run_refill(32'h0000_1080, 0, 0, 0);

        repeat (3) tick();
        chk("pending reads", rd_q.size(), 0);
        chk("pending updates", upd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
